// File: rtl/lynx_pkg.sv
// Shared constants and register payload type for the Lynx 48 I/O responder.
package lynx_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DAC_W  = 6;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned CNT_W  = 8;

    localparam logic [7:0] BANK_PORT_DFLT = 8'h7F;
    localparam logic [7:0] CTRL_PORT_DFLT = 8'h80;
    localparam logic [7:0] DAC_PORT_DFLT  = 8'h84;
    localparam int unsigned INT_LEN_DFLT  = 32;

    // vctrl bit that masks the frame interrupt
    localparam int unsigned VCTRL_MASK_BIT = 6;

    typedef struct packed {
        logic [DATA_W-1:0] bank;
        logic [DATA_W-1:0] vctrl;
        logic [DAC_W-1:0]  dac;
    } io_regs_t;

endpackage

// File: rtl/lynx_int_gen.sv
// Frame interrupt: vsync rise detect, mask check and fixed-length int_n pulse.
module lynx_int_gen
    import lynx_pkg::*;
#(
    parameter int unsigned INT_LEN = INT_LEN_DFLT
) (
    input  logic clock,
    input  logic reset,
    input  logic cep,
    input  logic vsync,
    input  logic mask,
    output logic int_n
);

    logic             vs_cur;
    logic             vs_prev;
    logic [CNT_W-1:0] cnt;
    logic             rise_c;

    assign rise_c = vs_cur & ~vs_prev;

    // Edges arriving during an active pulse are dropped; the mask is only sampled at pulse start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vs_cur  <= 1'b0;
            vs_prev <= 1'b0;
            cnt     <= '0;
            int_n   <= 1'b1;
        end else begin
            vs_cur  <= vsync;
            vs_prev <= vs_cur;
            if (int_n) begin
                if (rise_c && !mask) begin
                    int_n <= 1'b0;
                    cnt   <= CNT_W'(INT_LEN);
                end
            end else if (cep) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    int_n <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lynx_io.sv
// Z80 I/O-space responder: port write decode, read mux and frame interrupt.
module lynx_io
    import lynx_pkg::*;
#(
    parameter logic [7:0]  BANK_PORT = BANK_PORT_DFLT,
    parameter logic [7:0]  CTRL_PORT = CTRL_PORT_DFLT,
    parameter logic [7:0]  DAC_PORT  = DAC_PORT_DFLT,
    parameter int unsigned INT_LEN   = INT_LEN_DFLT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cep,
    input  logic              mreq,
    input  logic              iorq,
    input  logic              wr,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              q_en,
    output logic [ROW_W-1:0]  key_row,
    input  logic [DATA_W-1:0] key_data,
    input  logic              vsync,
    output logic [DATA_W-1:0] bank,
    output logic [DATA_W-1:0] vctrl,
    output logic [DAC_W-1:0]  dac,
    output logic              int_n
);

    io_regs_t regs;
    logic     wr_done;
    logic     io_wr_c;
    logic     io_rd_c;
    logic     unused_addr_c;

    assign io_wr_c       = cep & ~iorq & ~wr & mreq;
    assign io_rd_c       = ~iorq & wr & mreq;
    assign key_row       = a[11:8];
    assign unused_addr_c = ^a[15:12];

    assign bank  = regs.bank;
    assign vctrl = regs.vctrl;
    assign dac   = regs.dac;

    // Commit a port write once per IORQ cycle; wr_done re-arms when IORQ releases.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regs    <= '0;
            wr_done <= 1'b0;
        end else if (iorq) begin
            wr_done <= 1'b0;
        end else if (io_wr_c && !wr_done) begin
            wr_done <= 1'b1;
            if (a[7:0] == BANK_PORT) begin
                regs.bank <= d;
            end else if (a[7:0] == CTRL_PORT) begin
                regs.vctrl <= d;
            end else if (a[7:0] == DAC_PORT) begin
                regs.dac <= d[DAC_W-1:0];
            end
        end
    end

    // Zero-latency read mux; undecoded reads float the bus high.
    always_comb begin
        q    = 8'hFF;
        q_en = 1'b0;
        if (io_rd_c) begin
            if (a[7:0] == CTRL_PORT) begin
                q    = key_data;
                q_en = 1'b1;
            end else if (a[7:0] == BANK_PORT) begin
                q    = regs.bank;
                q_en = 1'b1;
            end
        end
    end

    lynx_int_gen #(
        .INT_LEN (INT_LEN)
    ) u_int_gen (
        .clock (clock),
        .reset (reset),
        .cep   (cep),
        .vsync (vsync),
        .mask  (regs.vctrl[VCTRL_MASK_BIT]),
        .int_n (int_n)
    );

endmodule

// File: doc/lynx_io.md
# lynx_io

Z80 I/O-space responder for the Lynx 48 core: the target end of the CPU bus, answering `IORQ` cycles from the T80 wrapper. It decodes port writes into the bank, video-control and speaker-DAC registers, and drives read data for port reads, including keyboard rows. It also generates the frame interrupt on `int_n` back to the CPU. It sits between the CPU wrapper and the memory/video/audio blocks, running on the system clock with the CPU's `cep` enable.

## Interface
Parameters:
- BANK_PORT, 8'h7F, `a[7:0]` match for the bank register
- CTRL_PORT, 8'h80, `a[7:0]` match for video control (write) and keyboard (read)
- DAC_PORT, 8'h84, `a[7:0]` match for the speaker DAC
- INT_LEN, 32, `int_n` low-pulse length in `cep` ticks (1..255)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low
- cep  in  1  CPU positive-phase clock enable; all bus sampling is qualified by it
- mreq  in  1  CPU `MREQ_n`, active-low
- iorq  in  1  CPU `IORQ_n`, active-low
- wr  in  1  CPU `WR_n`, active-low
- a  in  16  CPU address
- d  in  8  CPU data out (write data)
- q  out  8  read data to CPU `di` mux
- q_en  out  1  high when `q` is valid for a decoded port read
- key_row  out  4  keyboard row select, equal to `a[11:8]`
- key_data  in  8  selected keyboard row, active-low keys
- vsync  in  1  frame sync from video, active-high
- bank  out  8  bank register
- vctrl  out  8  video control register
- dac  out  6  speaker DAC level
- int_n  out  1  maskable interrupt to CPU, active-low

## Operation
- Reset (async assert, released synchronously at the next clock) forces:
  - `bank`, `vctrl`, `dac` = 0
  - `int_n` = 1, interrupt counter = 0, `wr_done` = 0, `vsync` history = 0
- I/O write condition (`io_wr`): `cep=1`, `iorq=0`, `wr=0`, `mreq=1`.
- Write commit:
  - Only on the first `io_wr` of a cycle, when `wr_done=0`; this sets `wr_done=1`.
  - `wr_done` clears on any clock where `iorq=1`.
  - A write held over many `cep` ticks commits once.
  - Targets, by exact `a[7:0]` match:
    - BANK_PORT → `bank <= d`
    - CTRL_PORT → `vctrl <= d`
    - DAC_PORT → `dac <= d[5:0]`
    - Any other port: no register changes, no error.
- Read path (combinational from bus inputs):
  - `iorq=0`, `wr=1`, `mreq=1` qualify a read.
  - CTRL_PORT → `q = key_data`, `q_en = 1`
  - BANK_PORT → `q = bank`, `q_en = 1`
  - Any other case → `q = 8'hFF`, `q_en = 0`
  - `key_row = a[11:8]` always.
- Interrupt:
  - `vsync` is registered every clock; a rising edge is `prev=0`, `cur=1`.
  - If `vctrl[6]=1` the interrupt is masked and the edge is dropped.
  - On an unmasked edge while idle: `int_n <= 0` and counter loads INT_LEN.
  - Each `cep` tick while active decrements the counter; on reaching 0, `int_n <= 1`.
  - A vsync edge during an active pulse is ignored: the pulse is neither extended nor queued.
  - Setting the mask during an active pulse does not cut the pulse short.

## Timing
- Register writes are visible on outputs one clock after the committing `cep` edge.
- Read data has zero latency (combinational); the CPU samples it on its own `cep`.
- `int_n` falls one clock after the clock on which the `vsync` rise is registered.
- `int_n` stays low for exactly INT_LEN `cep` ticks, counting from the first `cep` after the fall.
- Simultaneous write to CTRL_PORT setting `vctrl[6]` and a `vsync` edge: the mask is evaluated on the old `vctrl`, so the interrupt fires.
- Reset mid-pulse: `int_n` returns to 1 immediately (async).
- Reset mid-write: the register reads 0 after reset even if the write was in progress.
- Counter is 8 bits; INT_LEN=0 is illegal.

## Structure
- Shared package `lynx_pkg`: default port constants BANK_PORT, CTRL_PORT and DAC_PORT, plus the `vctrl` bit index for the interrupt mask (6).
- One sub-module, `lynx_int_gen`:
  - vsync edge detect, mask check, INT_LEN counter, `int_n`
  - inputs: `clock`, `reset`, `cep`, `vsync`, `mask`
- Decode, write-once logic and the read mux stay in `lynx_io`.

## Test plan
- Reset then idle: `bank`=0, `vctrl`=0, `dac`=0, `int_n`=1, `q`=FF, `q_en`=0.
- Write to port 0x7F with d=0x5A, `iorq`/`wr` held low for 6 `cep` ticks, `d` changed to 0x11 after the first tick → `bank`=0x5A (single commit); a read of 0x7F returns 0x5A with `q_en`=1.
- Write to 0x84 with d=0xFF → `dac`=0x3F. Write to 0x85 → no register changes. A write with `mreq`=0 → ignored.
- Read of port 0x0380 with `key_data`=0xFE → `key_row`=3, `q`=0xFE, `q_en`=1.
- `vsync` rise, INT_LEN=32, `cep` every 4th clock → `int_n` low for exactly 32 `cep` ticks. A second `vsync` rise at tick 10 does not extend the pulse. With `vctrl[6]`=1 → no pulse.
- Assert `reset` mid-pulse at tick 5 → `int_n`=1 within the same cycle (async); after release, no residual pulse.
